// File: rtl/button_mode_arbiter_pkg.sv
// Shared encodings for the button arbiter: FSM states, request indices, mode width.
// Also a one-hot helper reused by the picker and any neighbouring four-button logic.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } fsm_e;

  localparam int BTN_C4  = 0;
  localparam int BTN_E4  = 1;
  localparam int BTN_AB4 = 2;
  localparam int BTN_C5  = 3;

  localparam int MODE_W  = 2;
  localparam int N_BTN   = 4;

  function automatic logic [N_BTN-1:0] idx_to_onehot(input logic [MODE_W-1:0] idx);
    logic [N_BTN-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/button_mode_arbiter_if.sv
// Bundle between the debouncers, the arbiter and the mode consumers.
// Levels in (req); registered mode/grant/status out, plus the FSM state for observation.
interface button_mode_arbiter_if;
  import button_pkg::*;

  logic [N_BTN-1:0]  req;
  logic [MODE_W-1:0] state;
  logic [N_BTN-1:0]  grant;
  logic              mode_valid;
  logic              hold_busy;
  logic [N_BTN-1:0]  pending;
  fsm_e              fsm;

  // The arbiter side consumes button levels and drives everything else.
  modport master (
    input  req,
    output state, grant, mode_valid, hold_busy, pending, fsm
  );

  modport slave (
    output req,
    input  state, grant, mode_valid, hold_busy, pending, fsm
  );

endinterface

// File: rtl/button_mode_arbiter_rr_pick4.sv
// Combinational round-robin picker over four request bits.
// Search starts at last_grant+1 and wraps, so the most recently served bit ranks lowest.
module rr_pick4
  import button_pkg::*;
(
  input  logic [N_BTN-1:0]  pending,
  input  logic [MODE_W-1:0] last_grant,
  output logic [MODE_W-1:0] winner,
  output logic [N_BTN-1:0]  winner_oh,
  output logic              any
);

  always_comb begin
    logic [MODE_W-1:0] idx;
    winner    = '0;
    winner_oh = '0;
    any       = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_BTN; i++) begin
      idx = last_grant + MODE_W'(i + 1);
      if (!any && pending[idx]) begin
        any       = 1'b1;
        winner    = idx;
        winner_oh = idx_to_onehot(idx);
      end
    end
  end

endmodule

// File: rtl/button_mode_arbiter.sv
// Turns debounced button levels into queued one-shot requests and grants them one
// at a time, round-robin, holding each granted mode for at least HOLD_CYCLES cycles.
module button_mode_arbiter
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                 clk_50MHz,
  input  logic                 rst,
  button_mode_arbiter_if.master bus
);

  fsm_e              cur_st;
  fsm_e              nxt_st;
  logic [N_BTN-1:0]  req_q;
  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  pending_r;
  logic [N_BTN-1:0]  clr;
  logic [CNT_W-1:0]  counter;
  logic [MODE_W-1:0] last_grant;
  logic [MODE_W-1:0] state_r;
  logic [N_BTN-1:0]  grant_r;
  logic              mode_valid_r;
  logic              hold_busy_r;

  logic [MODE_W-1:0] winner;
  logic [N_BTN-1:0]  winner_oh;
  logic              any;

  assign rise = bus.req & ~req_q;

  rr_pick4 u_pick (
    .pending    (pending_r),
    .last_grant (last_grant),
    .winner     (winner),
    .winner_oh  (winner_oh),
    .any        (any)
  );

  always_ff @(posedge clk_50MHz) begin
    if (rst) cur_st <= ST_IDLE;
    else     cur_st <= nxt_st;
  end

  // GRANT only ever lasts one cycle; clr is the bit it retires from the queue.
  always_comb begin
    nxt_st = cur_st;
    clr    = '0;
    unique case (cur_st)
      ST_IDLE: begin
        if (|pending_r) nxt_st = ST_GRANT;
      end
      ST_GRANT: begin
        if (any) begin
          clr    = winner_oh;
          nxt_st = ST_HOLD;
        end else begin
          nxt_st = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (counter == '0) nxt_st = ST_IDLE;
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  // req_q tracks req even in reset so a button held through reset never fires.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      req_q        <= bus.req;
      pending_r    <= '0;
      state_r      <= '0;
      grant_r      <= '0;
      mode_valid_r <= 1'b0;
      hold_busy_r  <= 1'b0;
      counter      <= '0;
      last_grant   <= MODE_W'(BTN_C5);
    end else begin
      req_q     <= bus.req;
      pending_r <= (pending_r & ~clr) | rise;
      grant_r   <= '0;
      unique case (cur_st)
        ST_GRANT: begin
          if (any) begin
            state_r      <= winner;
            grant_r      <= winner_oh;
            mode_valid_r <= 1'b1;
            last_grant   <= winner;
            counter      <= CNT_W'(HOLD_CYCLES - 1);
            hold_busy_r  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (counter == '0) hold_busy_r <= 1'b0;
          else               counter     <= counter - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.state      = state_r;
  assign bus.grant      = grant_r;
  assign bus.mode_valid = mode_valid_r;
  assign bus.hold_busy  = hold_busy_r;
  assign bus.pending    = pending_r;
  assign bus.fsm        = cur_st;

endmodule

// File: tb/tb_button_mode_arbiter.sv
// Directed bench for button_mode_arbiter with HOLD_CYCLES=4: grants are checked by a
// scoreboard monitor against an expected queue, other outputs by directed checks.
module tb_button_mode_arbiter;
  import button_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [5:0] exp_q[$];

  button_mode_arbiter_if bus();

  button_mode_arbiter #(.HOLD_CYCLES(4), .CNT_W(4)) dut (
    .clk_50MHz (clk),
    .rst       (rst),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (!(bus.fsm == ST_IDLE && !bus.hold_busy) && c < 100) begin
      tick();
      c++;
    end
    chk("idle_timeout", 8'(c < 100), 8'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},   8'(bus.state),      8'h0);
    chk({tag, "_grant"},   8'(bus.grant),      8'h0);
    chk({tag, "_valid"},   8'(bus.mode_valid), 8'h0);
    chk({tag, "_busy"},    8'(bus.hold_busy),  8'h0);
    chk({tag, "_pending"}, 8'(bus.pending),    8'h0);
    chk({tag, "_fsm"},     8'(bus.fsm),        8'(ST_IDLE));
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic run_monitor();
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (bus.grant != '0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_grant: got grant=%b state=%0d with nothing expected", bus.grant, bus.state);
        end else begin
          e = exp_q.pop_front();
          chk("sb_grant_state", 8'({bus.grant, bus.state}), 8'(e));
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] g;
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    bus.req = 4'b0000;
    fork
      run_monitor();
    join_none

    // AB4 held through reset must not fire; a fresh press does.
    bus.req = 4'b0100;
    do_reset(2);
    chk_reset_outputs("rst1");
    repeat (3) tick();
    chk("held_pending", 8'(bus.pending), 8'h0);
    chk("held_valid",   8'(bus.mode_valid), 8'h0);
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0100;
    exp_q.push_back({4'b0100, 2'd2});
    tick();
    chk("ab4_pending", 8'(bus.pending), 8'h4);
    tick();
    chk("ab4_grant_early", 8'(bus.grant), 8'h0);
    tick();
    chk("ab4_grant", 8'(bus.grant), 8'h4);
    chk("ab4_state", 8'(bus.state), 8'h2);
    bus.req = 4'b0000;
    wait_idle();

    // Single E4 press: latency, grant pulse width, dwell length.
    bus.req = 4'b0010;
    exp_q.push_back({4'b0010, 2'd1});
    tick();
    chk("e4_pending", 8'(bus.pending), 8'h2);
    tick();
    tick();
    chk("e4_grant", 8'(bus.grant), 8'h2);
    chk("e4_state", 8'(bus.state), 8'h1);
    chk("e4_valid", 8'(bus.mode_valid), 8'h1);
    chk("e4_busy0", 8'(bus.hold_busy), 8'h1);
    chk("e4_pending_clr", 8'(bus.pending), 8'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("e4_busy", 8'(bus.hold_busy), 8'h1);
      chk("e4_pulse_end", 8'(bus.grant), 8'h0);
    end
    tick();
    chk("e4_busy_done", 8'(bus.hold_busy), 8'h0);
    chk("e4_state_hold", 8'(bus.state), 8'h1);
    bus.req = 4'b0000;
    wait_idle();

    // All four rising together after reset: served 0,1,2,3 six cycles apart.
    do_reset(2);
    chk_reset_outputs("rst2");
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) exp_q.push_back({4'(4'b0001 << k), 2'(k)});
    tick();
    chk("all_pending", 8'(bus.pending), 8'hf);
    tick();
    tick();
    chk("all_grant0", 8'(bus.grant), 8'h1);
    chk("all_state0", 8'(bus.state), 8'h0);
    bus.req = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      for (int j = 0; j < 5; j++) begin
        tick();
        chk("all_gap", 8'(bus.grant), 8'h0);
      end
      tick();
      g = 4'b0001 << k;
      chk("all_grant", 8'(bus.grant), 8'(g));
      chk("all_state", 8'(bus.state), 8'(k));
    end
    chk("all_pending_end", 8'(bus.pending), 8'h0);

    // last_grant=C5: E4 and AB4 pressed during HOLD, wrap gives E4 then AB4.
    tick();
    bus.req = 4'b0110;
    exp_q.push_back({4'b0010, 2'd1});
    exp_q.push_back({4'b0100, 2'd2});
    tick();
    chk("wrap_pending", 8'(bus.pending), 8'h6);
    repeat (4) tick();
    chk("wrap_grant_e4", 8'(bus.grant), 8'h2);
    chk("wrap_state_e4", 8'(bus.state), 8'h1);
    bus.req = 4'b0000;
    repeat (6) tick();
    chk("wrap_grant_ab4", 8'(bus.grant), 8'h4);
    chk("wrap_state_ab4", 8'(bus.state), 8'h2);
    wait_idle();

    // C4 re-pressed on the very edge its grant clears it: set wins.
    exp_q.push_back({4'b0001, 2'd0});
    exp_q.push_back({4'b0001, 2'd0});
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0001;
    tick();
    chk("repress_grant", 8'(bus.grant), 8'h1);
    chk("repress_pending", 8'(bus.pending), 8'h1);
    bus.req = 4'b0000;
    repeat (6) tick();
    chk("repress_grant2", 8'(bus.grant), 8'h1);
    chk("repress_pending2", 8'(bus.pending), 8'h0);
    wait_idle();

    // Reset two cycles into HOLD with C5 pending: everything aborts.
    exp_q.push_back({4'b0001, 2'd0});
    bus.req = 4'b0001;
    repeat (3) tick();
    chk("abort_grant", 8'(bus.grant), 8'h1);
    bus.req = 4'b1001;
    tick();
    chk("abort_pending", 8'(bus.pending), 8'h8);
    chk("abort_busy", 8'(bus.hold_busy), 8'h1);
    chk("abort_fsm", 8'(bus.fsm), 8'(ST_HOLD));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("abort");
    repeat (12) tick();
    chk("abort_quiet_pending", 8'(bus.pending), 8'h0);
    chk("abort_quiet_valid", 8'(bus.mode_valid), 8'h0);
    chk("abort_quiet_state", 8'(bus.state), 8'h0);

    chk("queue_empty", 8'(exp_q.size()), 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_mode_arbiter.md
Name: button_mode_arbiter

Overview:
- Sequencer and arbiter sitting between the four debouncer outputs (C4, E4, AB4, C5) and the downstream mode-consuming logic.
- Converts debounced button levels into one-shot requests and queues them as pending.
- Grants one request at a time with round-robin fairness and drives the 2-bit mode `state`.
- Enforces a minimum dwell of HOLD_CYCLES before the next mode change, so simultaneous or rapid presses are serialised and never lost.

Parameters:
- HOLD_CYCLES, 50_000_000; minimum cycles a granted mode is held before another grant (1 s at 50 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 26; width of the dwell counter.

Ports:
- clk_50MHz  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  debounced button levels; bit0=C4, bit1=E4, bit2=AB4, bit3=C5.
- state  output  2  current mode index (binary index of the last granted bit).
- grant  output  4  one-hot, 1-cycle pulse marking the newly granted request.
- mode_valid  output  1  0 until the first grant after reset, then 1.
- hold_busy  output  1  1 while the dwell counter is running (HOLD state).
- pending  output  4  queued, not-yet-served requests.

Behaviour:
- Interface: one clock (clk_50MHz); reset is synchronous and active-high (rst).
- Reset values, applied at the first clk edge with rst=1:
  - state=2'b00, grant=0, mode_valid=0, hold_busy=0, pending=0.
  - FSM=IDLE, counter=0, last_grant=3.
  - req_q<=req, so a button held through reset does not fire on release.
  - Presses while rst=1 are discarded.
  - Reset mid-HOLD or mid-GRANT aborts at once; no grant pulse is emitted.
- Edge detect: rise = req & ~req_q. req_q is registered every cycle.
- Pending: pending <= (pending & ~clr) | rise.
  - clr is the one-hot winner in GRANT, else 0.
  - A new rise on the bit being cleared in the same cycle keeps that bit set (set wins).
  - A re-press of a bit already pending is absorbed; no counting.
- FSM states IDLE, GRANT, HOLD:
  - IDLE: pending!=0 -> GRANT; otherwise stay.
  - GRANT (exactly 1 cycle):
    - Winner is the first set pending bit searching from (last_grant+1) mod 4 upward with wrap.
    - Registered updates: state=winner index, grant=one-hot winner, mode_valid=1, last_grant=winner, pending bit cleared, counter=HOLD_CYCLES-1, hold_busy=1.
    - Next state is HOLD.
  - HOLD: counter decrements each cycle. When counter==0, hold_busy=0 and next state is IDLE. Rises keep accumulating into pending.
- grant returns to 0 on the cycle after its pulse. state holds between grants.
- Latency: req first sampled high at edge n -> pending bit visible after edge n -> GRANT after edge n+1 -> state/grant updated after edge n+2.
- Minimum spacing between consecutive grant pulses is HOLD_CYCLES+2 cycles. Back-to-back pending requests are served at exactly that rate.
- Simultaneous rises on several bits: all are queued. Service follows round-robin order from last_grant+1.
- Button released before its grant: the request is still served, because pending is edge-based.
- Counter width: no wrap; the decrement never goes below 0.

Decomposition:
- Shared package button_pkg holds:
  - FSM encodings ST_IDLE, ST_GRANT, ST_HOLD (2-bit).
  - Request index constants BTN_C4=0, BTN_E4=1, BTN_AB4=2, BTN_C5=3.
  - Mode width MODE_W=2.
- One combinational sub-module rr_pick4:
  - Inputs: pending[3:0], last_grant[1:0].
  - Outputs: winner[1:0], winner_oh[3:0], any.
  - Reusable wherever the board shares a resource among four buttons.

Test Plan (HOLD_CYCLES=4):
- Reset with req=4'b0100 held, then release rst -> no grant, pending=0, state=00, mode_valid=0. Releasing and re-pressing AB4 -> grant=4'b0100 two cycles later, state=10.
- Single press E4 at edge n -> pending=0010 after n, grant=0010 pulse and state=01 after n+2, hold_busy=1 for 4 cycles then 0.
- req=4'b1111 rising together after reset -> grants in order 0001, 0010, 0100, 1000 with state 00, 01, 10, 11, pulses spaced 6 cycles apart, pending ending 0000.
- State after grant of C5 (last_grant=3); press E4 and AB4 during HOLD -> E4 granted first, then AB4 (round-robin wrap from 0).
- C4 re-pressed in the same cycle its grant clears it -> pending bit0 stays 1, C4 granted again 6 cycles later.
- rst asserted 2 cycles into HOLD with pending=1000 -> next cycle all outputs at reset values and no further grant appears.
